// File: rtl/edge_trig_sched.sv
// Round-robin scheduler for N requesters that share one external registered
// compare-add/sub unit. Only one operation is in flight at any time.
module edge_trig_sched #(
    parameter int N       = 4,
    parameter int W       = 8,
    parameter int ALU_LAT = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [N-1:0]     req_valid_i,
    output logic [N-1:0]     req_ready_o,
    input  logic [N*W-1:0]   req_a_i,
    input  logic [N*W-1:0]   req_b_i,
    output logic [N-1:0]     rsp_valid_o,
    input  logic [N-1:0]     rsp_ready_i,
    output logic [W-1:0]     rsp_data_o,
    output logic [W-1:0]     alu_a_o,
    output logic [W-1:0]     alu_b_o,
    input  logic [W-1:0]     alu_res_i,
    output logic             busy_o
);

    localparam int IDW = $clog2(N);
    localparam int CW  = $clog2(ALU_LAT + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t          state_q;
    logic [IDW-1:0]  gid_q;
    logic [IDW-1:0]  ptr_q;
    logic [CW-1:0]   cnt_q;
    logic [N-1:0]    req_ready_q;
    logic [N-1:0]    rsp_valid_q;
    logic [W-1:0]    rsp_data_q;
    logic [W-1:0]    alu_a_q;
    logic [W-1:0]    alu_b_q;
    logic            busy_q;

    logic [IDW-1:0]  gid_d;
    logic [IDW-1:0]  ptr_d;
    logic [W-1:0]    alu_a_d;
    logic [W-1:0]    alu_b_d;
    logic [W-1:0]    a_arr_s [N];
    logic [W-1:0]    b_arr_s [N];

    // First valid requester at or above the pointer, wrapping; later hits in
    // the descending scan overwrite earlier ones, so the nearest one wins.
    function automatic logic [IDW-1:0] pick(input logic [N-1:0] v, input logic [IDW-1:0] p);
        logic [IDW-1:0] r;
        int             idx;
        r = p;
        for (int k = N - 1; k >= 0; k--) begin
            idx = (int'(p) + k) % N;
            if (v[idx[IDW-1:0]]) begin
                r = idx[IDW-1:0];
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

    function automatic logic [N-1:0] onehot(input logic [IDW-1:0] i);
        logic [N-1:0] r;
        r    = '0;
        r[i] = 1'b1;
        return r;
    endfunction

    for (genvar g = 0; g < N; g++) begin : g_slice
        assign a_arr_s[g] = req_a_i[g*W +: W];
        assign b_arr_s[g] = req_b_i[g*W +: W];
    end

    // Arbitration result, operand mux and pointer advance for the current grant.
    always_comb begin
        gid_d   = pick(req_valid_i, ptr_q);
        alu_a_d = a_arr_s[gid_q];
        alu_b_d = b_arr_s[gid_q];
        ptr_d   = (gid_q == IDW'(N - 1)) ? '0 : gid_q + 1'b1;
    end

    // Scheduler FSM with all handshake and ALU outputs registered.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            gid_q       <= '0;
            ptr_q       <= '0;
            cnt_q       <= '0;
            req_ready_q <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (|req_valid_i) begin
                        gid_q       <= gid_d;
                        req_ready_q <= onehot(gid_d);
                        busy_q      <= 1'b1;
                        state_q     <= S_GRANT;
                    end else begin
                        state_q     <= S_IDLE;
                    end
                end
                S_GRANT: begin
                    req_ready_q <= '0;
                    if (req_valid_i[gid_q]) begin
                        alu_a_q <= alu_a_d;
                        alu_b_q <= alu_b_d;
                        cnt_q   <= '0;
                        state_q <= S_WAIT;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                S_WAIT: begin
                    if (cnt_q == CW'(ALU_LAT)) begin
                        rsp_data_q  <= alu_res_i;
                        rsp_valid_q <= onehot(gid_q);
                        state_q     <= S_RESP;
                    end else begin
                        cnt_q       <= cnt_q + 1'b1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready_i[gid_q]) begin
                        rsp_valid_q <= '0;
                        ptr_q       <= ptr_d;
                        busy_q      <= 1'b0;
                        state_q     <= S_IDLE;
                    end else begin
                        state_q     <= S_RESP;
                    end
                end
                default: begin
                    req_ready_q <= '0;
                    rsp_valid_q <= '0;
                    busy_q      <= 1'b0;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready_o = req_ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_data_o  = rsp_data_q;
    assign alu_a_o     = alu_a_q;
    assign alu_b_o     = alu_b_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_edge_trig_sched.sv
// Directed bench for edge_trig_sched with a registered model of the shared
// compare-add/sub unit (one cycle latency).
module tb_edge_trig_sched;

    localparam int N = 4;
    localparam int W = 8;
    localparam int L = 1;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic [N-1:0]   rsp_valid;
    logic [N-1:0]   rsp_ready;
    logic [W-1:0]   rsp_data;
    logic [W-1:0]   alu_a;
    logic [W-1:0]   alu_b;
    logic [W-1:0]   alu_res = '0;
    logic           busy;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        int         id;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs [6];

    edge_trig_sched #(.N(N), .W(W), .ALU_LAT(L)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_a_i     (req_a),
        .req_b_i     (req_b),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_data_o  (rsp_data),
        .alu_a_o     (alu_a),
        .alu_b_o     (alu_b),
        .alu_res_i   (alu_res),
        .busy_o      (busy)
    );

    always #5 clk = ~clk;

    // Model of the external unit: registered A>B ? A+B : A-B, truncated to W bits.
    always_ff @(posedge clk) begin
        alu_res <= (alu_a > alu_b) ? alu_a + alu_b : alu_a - alu_b;
    end

    function automatic logic [N-1:0] oh(input int i);
        logic [N-1:0] r;
        r = '0;
        r[i] = 1'b1;
        return r;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic wait_grant(input int g);
        int k;
        k = 0;
        while (req_ready == '0 && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("grant_onehot", 32'(req_ready), 32'(oh(g)));
    endtask

    task automatic wait_rsp(input int g, input logic [7:0] exp);
        int k;
        k = 0;
        while (rsp_valid == '0 && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("rsp_onehot", 32'(rsp_valid), 32'(oh(g)));
        check("rsp_data", 32'(rsp_data), 32'(exp));
        check("no_ready_in_resp", 32'(req_ready), 32'd0);
    endtask

    // One isolated transaction checked cycle by cycle from the IDLE state.
    task automatic run_one(input vec_t v);
        @(negedge clk);
        req_valid = '0;
        req_valid[v.id] = 1'b1;
        req_a[v.id*8 +: 8] = v.a;
        req_b[v.id*8 +: 8] = v.b;
        @(negedge clk);
        check("t1_ready", 32'(req_ready), 32'(oh(v.id)));
        check("t1_busy", 32'(busy), 32'd1);
        @(negedge clk);
        req_valid = '0;
        check("t2_ready_low", 32'(req_ready), 32'd0);
        check("t2_alu_a", 32'(alu_a), 32'(v.a));
        check("t2_alu_b", 32'(alu_b), 32'(v.b));
        @(negedge clk);
        check("t3_rsp_low", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        check("t4_rsp_valid", 32'(rsp_valid), 32'(oh(v.id)));
        check("t4_rsp_data", 32'(rsp_data), 32'(v.exp));
        rsp_ready[v.id] = 1'b1;
        @(negedge clk);
        check("t5_rsp_low", 32'(rsp_valid), 32'd0);
        check("t5_idle", 32'(busy), 32'd0);
        rsp_ready = '0;
    endtask

    initial begin
        vecs[0] = '{id: 0, a: 8'd200, b: 8'd100, exp: 8'd44};
        vecs[1] = '{id: 2, a: 8'd5,   b: 8'd9,   exp: 8'd252};
        vecs[2] = '{id: 2, a: 8'd7,   b: 8'd7,   exp: 8'd0};
        vecs[3] = '{id: 1, a: 8'd255, b: 8'd1,   exp: 8'd0};
        vecs[4] = '{id: 3, a: 8'd0,   b: 8'd255, exp: 8'd1};
        vecs[5] = '{id: 1, a: 8'd10,  b: 8'd3,   exp: 8'd13};

        rst = 1'b1;
        req_valid = '0;
        rsp_ready = '0;
        req_a = '0;
        req_b = '0;
        @(negedge clk);
        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_data", 32'(rsp_data), 32'd0);
        check("rst_alu_a", 32'(alu_a), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            run_one(vecs[i]);
        end

        // Round robin with all requesters valid, then only 1 and 3.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < N; i++) begin
            req_a[i*8 +: 8] = 8'(20 + 10 * i);
            req_b[i*8 +: 8] = 8'(i);
        end
        rsp_ready = 4'b1111;
        req_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            wait_grant(k % 4);
            if (k == 7) begin
                @(negedge clk);
                req_valid = 4'b1010;
            end else begin
                @(negedge clk);
            end
            wait_rsp(k % 4, 8'(20 + 11 * (k % 4)));
        end
        wait_grant(1);
        wait_rsp(1, 8'd31);
        wait_grant(3);
        @(negedge clk);
        req_valid = '0;
        wait_rsp(3, 8'd53);
        @(negedge clk);

        // Response back-pressure: hold for five cycles with another request pending.
        rsp_ready = '0;
        req_a[15:8] = 8'd50;
        req_b[15:8] = 8'd20;
        req_valid = 4'b0010;
        wait_grant(1);
        @(negedge clk);
        req_valid = 4'b0001;
        wait_rsp(1, 8'd70);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("hold_rsp_valid", 32'(rsp_valid), 32'b0010);
            check("hold_rsp_data", 32'(rsp_data), 32'd70);
            check("hold_no_ready", 32'(req_ready), 32'd0);
        end
        rsp_ready = 4'b1111;
        @(negedge clk);
        check("hold_release", 32'(rsp_valid), 32'd0);
        wait_grant(0);
        @(negedge clk);
        req_valid = '0;
        wait_rsp(0, 8'd20);
        @(negedge clk);

        // Asynchronous reset while a response is held.
        rsp_ready = '0;
        req_a[23:16] = 8'd5;
        req_b[23:16] = 8'd9;
        req_valid = 4'b0100;
        wait_grant(2);
        @(negedge clk);
        req_valid = '0;
        wait_rsp(2, 8'd252);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("arst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("arst_rsp_data", 32'(rsp_data), 32'd0);
        check("arst_alu_a", 32'(alu_a), 32'd0);
        check("arst_alu_b", 32'(alu_b), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_busy", 32'(busy), 32'd0);
        check("post_rst_rsp", 32'(rsp_valid), 32'd0);

        // Reset during WAIT: pointer returns to 0 and the old op is dropped.
        rsp_ready = 4'b1111;
        req_valid = 4'b0100;
        wait_grant(2);
        @(negedge clk);
        check("wait_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        req_valid = 4'b1001;
        wait_grant(0);
        check("no_stale_rsp", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        req_valid = 4'b1000;
        wait_rsp(0, 8'd20);
        wait_grant(3);
        @(negedge clk);
        req_valid = '0;
        wait_rsp(3, 8'd53);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
